// File: rtl/hash_display_pkg.sv
// Shared types and the rolling-hash step for the student-ID hash display.
package hash_display_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 5;
    localparam int HASH_W     = 16;

    typedef logic [BCD_W-1:0]                  bcd_digit_t;
    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0]  bcd_digits_t;

    // Byte-swap, mix in the key, then add the running time stamp (mod 2^16).
    function automatic logic [HASH_W-1:0] hash_next(
        input logic [HASH_W-1:0] cur_hash,
        input logic [HASH_W-1:0] student_id,
        input logic [HASH_W-1:0] cur_time
    );
        logic [HASH_W-1:0] swapped;
        swapped   = {cur_hash[7:0], cur_hash[15:8]};
        hash_next = (swapped ^ student_id) + cur_time;
    endfunction

endpackage

// File: rtl/hash_display_top_bin2bcd16.sv
// Combinational 16-bit binary to five BCD digits (double dabble).
module bin2bcd16
    import hash_display_pkg::*;
(
    input  logic [15:0] bin_i,
    output bcd_digits_t bcd_o
);

    localparam int SCR_W = 16 + NUM_DIGITS * BCD_W;

    logic [SCR_W-1:0] scratch;

    always_comb begin
        scratch = {{(NUM_DIGITS * BCD_W){1'b0}}, bin_i};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (scratch[16 + 4*d +: 4] >= 4'd5) begin
                    scratch[16 + 4*d +: 4] = scratch[16 + 4*d +: 4] + 4'd3;
                end
            end
            scratch = {scratch[SCR_W-2:0], 1'b0};
        end
        bcd_o = scratch[SCR_W-1:16];
    end

endmodule

// File: rtl/hash_display_top.sv
// Button-toggled rolling hash of the student ID, shown as five BCD digits.
module hash_display_top
    import hash_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 2000,
    parameter int KEYCHANGE_CYCLES = 5_000_000
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        button_in,
    input  logic [15:0] student_id,
    output logic [3:0]  D5_out,
    output logic [3:0]  D4_out,
    output logic [3:0]  D3_out,
    output logic [3:0]  D2_out,
    output logic [3:0]  D1_out
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (KEYCHANGE_CYCLES > 1) ? $clog2(KEYCHANGE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(KEYCHANGE_CYCLES - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              btn_db_q, btn_db_d;
    logic              btn_prev_q, btn_prev_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              enable_q, enable_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [15:0]       cur_hash_q, cur_hash_d;
    logic [15:0]       cur_time_q, cur_time_d;
    bcd_digits_t       digits_q, digits_d;

    logic              press;
    logic              tick;
    bcd_digits_t       bcd;

    bin2bcd16 u_bcd (
        .bin_i (cur_hash_q),
        .bcd_o (bcd)
    );

    always_comb begin
        sync1_d    = button_in;
        sync2_d    = sync1_q;
        btn_db_d   = btn_db_q;
        btn_prev_d = btn_db_q;
        db_cnt_d   = '0;
        div_cnt_d  = '0;
        cur_hash_d = cur_hash_q;
        cur_time_d = cur_time_q;
        digits_d   = bcd;

        // Accept a new level only after it has differed for the full window.
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        press    = btn_db_q & ~btn_prev_q;
        enable_d = enable_q ^ press;

        // A press that disables on the terminal count swallows that tick.
        tick = enable_q & ~press & (div_cnt_q == DIV_LAST);

        if (enable_q && (div_cnt_q != DIV_LAST)) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (tick) begin
            cur_hash_d = hash_next(cur_hash_q, student_id, cur_time_q);
            cur_time_d = cur_time_q + 16'd1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            enable_q   <= 1'b0;
            div_cnt_q  <= '0;
            cur_hash_q <= '0;
            cur_time_q <= '0;
            digits_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_db_q   <= btn_db_d;
            btn_prev_q <= btn_prev_d;
            db_cnt_q   <= db_cnt_d;
            enable_q   <= enable_d;
            div_cnt_q  <= div_cnt_d;
            cur_hash_q <= cur_hash_d;
            cur_time_q <= cur_time_d;
            digits_q   <= digits_d;
        end
    end

    assign D5_out = digits_q[4];
    assign D4_out = digits_q[3];
    assign D3_out = digits_q[2];
    assign D2_out = digits_q[1];
    assign D1_out = digits_q[0];

endmodule

// File: tb/tb_hash_display_top.sv
// Directed bench for hash_display_top with a cycle-level reference model.
module tb_hash_display_top;

    localparam int DB = 4;
    localparam int KC = 10;
    localparam int SID = 4660;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        button_in = 1'b0;
    logic [15:0] student_id = 16'(SID);
    logic [3:0]  D5_out, D4_out, D3_out, D2_out, D1_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_hist [DB+2];
    bit m_db, m_rose, m_en, m_live;
    int m_run, m_hash, m_time, m_disp;

    hash_display_top #(
        .DEBOUNCE_CYCLES  (DB),
        .KEYCHANGE_CYCLES (KC)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .button_in  (button_in),
        .student_id (student_id),
        .D5_out     (D5_out),
        .D4_out     (D4_out),
        .D3_out     (D3_out),
        .D2_out     (D2_out),
        .D1_out     (D1_out)
    );

    always #5 sysclk = ~sysclk;

    function automatic int digits_of(input int v);
        return (v / 10000) * 65536 + ((v / 1000) % 10) * 4096
             + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
    endfunction

    function automatic int model_hash(input int h, input int t);
        int rot;
        rot = (h % 256) * 256 + h / 256;
        return ((rot ^ SID) + t) % 65536;
    endfunction

    task automatic check(input string name, input logic [19:0] act,
                         input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] shown();
        return {D5_out, D4_out, D3_out, D2_out, D1_out};
    endfunction

    // Model: button accepted when the last DB synchronized samples all
    // disagree with the accepted level; ticks every KC enabled cycles.
    initial begin
        bit press_now, all_diff;
        forever begin
            @(posedge sysclk);
            if (rst) begin
                foreach (m_hist[k]) m_hist[k] = 1'b0;
                m_db = 0; m_rose = 0; m_en = 0;
                m_run = 0; m_hash = 0; m_time = 0; m_disp = 0;
                m_live = 1;
            end else begin
                for (int k = DB + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = button_in;
                press_now = m_rose;
                m_disp = digits_of(m_hash);
                if (m_en) begin
                    if (press_now) begin
                        m_en = 0;
                        m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run == KC) begin
                            m_run = 0;
                            m_hash = model_hash(m_hash, m_time);
                            m_time = (m_time + 1) % 65536;
                        end
                    end
                end else if (press_now) begin
                    m_en = 1;
                    m_run = 0;
                end
                all_diff = 1;
                for (int k = 2; k < DB + 2; k++)
                    if (m_hist[k] == m_db) all_diff = 0;
                m_rose = 0;
                if (all_diff) begin
                    m_db = !m_db;
                    m_rose = m_db;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (m_live) check("digits_vs_model", shown(), 20'(m_disp));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        rst = 1'b1;
        button_in = 1'b0;
        step(3);
        check("reset", shown(), 20'h00000);
        rst = 1'b0;
        step(10);
        check("idle", shown(), 20'h00000);

        button_in = 1'b1;
        step(6);
        button_in = 1'b0;
        step(13);
        check("tick1", shown(), 20'h04660);
        check("model_tick1", 20'(m_hash), 20'd4660);

        step(10);
        check("tick2", shown(), 20'h09767);
        check("model_tick2", 20'(m_hash), 20'd9767);

        button_in = 1'b1;
        step(6);
        button_in = 1'b0;
        step(50);
        check("hold_disabled", shown(), 20'h09767);

        button_in = 1'b1;
        step(3);
        button_in = 1'b0;
        step(30);
        check("glitch", shown(), 20'h09767);

        button_in = 1'b1;
        step(6);
        button_in = 1'b0;
        step(13);
        check("tick3", shown(), 20'h13588);
        check("model_tick3", 20'(m_hash), 20'd13588);

        rst = 1'b1;
        step(1);
        check("mid_reset", shown(), 20'h00000);
        rst = 1'b0;
        step(5);
        check("post_reset", shown(), 20'h00000);

        button_in = 1'b1;
        step(6);
        button_in = 1'b0;
        step(13);
        check("restart", shown(), 20'h04660);
        check("model_restart", 20'(m_hash), 20'd4660);

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
